bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq.sv | 131 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
// One input bit is consumed per clock; four decimal digits are produced after N
// shifts and presented with a one-cycle done_tick. A start/ready handshake lets
// the converter be retriggered whenever the source counter changes.
module bin2bcd_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] bin,
    output logic         ready,
    output logic         done_tick,
    output logic [3:0]   bcd3,
    output logic [3:0]   bcd2,
    output logic [3:0]   bcd1,
    output logic [3:0]   bcd0
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        OP,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   shReg_q;
    logic [3:0]     w3_q, w2_q, w1_q, w0_q;
    logic [CW-1:0]  bitCnt_q;
    logic [3:0]     bcd3_q, bcd2_q, bcd1_q, bcd0_q;

    logic [2:0]     adj3Low_d;
    logic [3:0]     adj2_d, adj1_d, adj0_d;
    logic [3:0]     w3_d, w2_d, w1_d, w0_d;
    logic [N-1:0]   shReg_d;
    logic           lastShift;

    // Correct-then-shift step for one OP cycle. Only the low three bits of the
    // corrected thousands digit survive the shift, so only those are formed.
    always_comb begin
        adj3Low_d = (w3_q >= 4'd5) ? (w3_q[2:0] + 3'd3) : w3_q[2:0];
        adj2_d    = (w2_q >= 4'd5) ? (w2_q + 4'd3) : w2_q;
        adj1_d    = (w1_q >= 4'd5) ? (w1_q + 4'd3) : w1_q;
        adj0_d    = (w0_q >= 4'd5) ? (w0_q + 4'd3) : w0_q;
        w3_d      = {adj3Low_d, adj2_d[3]};
        w2_d      = {adj2_d[2:0], adj1_d[3]};
        w1_d      = {adj1_d[2:0], adj0_d[3]};
        w0_d      = {adj0_d[2:0], shReg_q[N-1]};
        shReg_d   = shReg_q << 1;
        lastShift = (bitCnt_q == CW'(1));
    end

    // State register, cleared asynchronously so a conversion aborts at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is honoured only in IDLE, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = OP;
            OP:      if (lastShift) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded directly from the current state.
    always_comb begin
        ready     = (state_q == IDLE);
        done_tick = (state_q == DONE);
    end

    // Datapath: load on accepted start, correct/shift during OP, and latch the
    // displayed digits only on the final shift so the display never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shReg_q  <= '0;
            w3_q     <= '0;
            w2_q     <= '0;
            w1_q     <= '0;
            w0_q     <= '0;
            bitCnt_q <= '0;
            bcd3_q   <= '0;
            bcd2_q   <= '0;
            bcd1_q   <= '0;
            bcd0_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shReg_q  <= bin;
                        w3_q     <= '0;
                        w2_q     <= '0;
                        w1_q     <= '0;
                        w0_q     <= '0;
                        bitCnt_q <= CW'(N);
                    end
                end
                OP: begin
                    shReg_q  <= shReg_d;
                    w3_q     <= w3_d;
                    w2_q     <= w2_d;
                    w1_q     <= w1_d;
                    w0_q     <= w0_d;
                    bitCnt_q <= bitCnt_q - CW'(1);
                    if (lastShift) begin
                        bcd3_q <= w3_d;
                        bcd2_q <= w2_d;
                        bcd1_q <= w1_d;
                        bcd0_q <= w0_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd3 = bcd3_q;
    assign bcd2 = bcd2_q;
    assign bcd1 = bcd1_q;
    assign bcd0 = bcd0_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed bench for bin2bcd_seq with an N=8 and an N=13
// instance. Expected digits are hand-computed decimal values of each input.
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset;

    logic        start8;
    logic [7:0]  bin8;
    logic        ready8, done8;
    logic [3:0]  d8_3, d8_2, d8_1, d8_0;

    logic        start13;
    logic [12:0] bin13;
    logic        ready13, done13;
    logic [3:0]  d13_3, d13_2, d13_1, d13_0;

    int vectors    = 0;
    int miscompares = 0;

    bin2bcd_seq #(.N(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start8),
        .bin       (bin8),
        .ready     (ready8),
        .done_tick (done8),
        .bcd3      (d8_3),
        .bcd2      (d8_2),
        .bcd1      (d8_1),
        .bcd0      (d8_0)
    );

    bin2bcd_seq #(.N(13)) dut13 (
        .clk       (clk),
        .reset     (reset),
        .start     (start13),
        .bin       (bin13),
        .ready     (ready13),
        .done_tick (done13),
        .bcd3      (d13_3),
        .bcd2      (d13_2),
        .bcd1      (d13_1),
        .bcd0      (d13_0)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where outputs are settled.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] digitsOf(input int sel);
        return (sel == 13) ? {d13_3, d13_2, d13_1, d13_0} : {d8_3, d8_2, d8_1, d8_0};
    endfunction

    function automatic logic [15:0] doneOf(input int sel);
        return {15'd0, (sel == 13) ? done13 : done8};
    endfunction

    function automatic logic [15:0] readyOf(input int sel);
        return {15'd0, (sel == 13) ? ready13 : ready8};
    endfunction

    task automatic applyStimulus(input int sel, input logic startVal, input int value);
        if (sel == 13) begin
            start13 = startVal;
            bin13   = value[12:0];
        end else begin
            start8 = startVal;
            bin8   = value[7:0];
        end
    endtask

    // One full conversion: start accepted at edge k, done at edge k+N,
    // previous digits held in between, ready again at edge k+N+1.
    task automatic runConversion(input int sel, input int value,
                                 input logic [15:0] expBcd, input logic [15:0] prevBcd);
        int n;
        n = (sel == 13) ? 13 : 8;
        applyStimulus(sel, 1'b1, value);
        tick;
        applyStimulus(sel, 1'b0, 0);
        checkOutput("busy after accept", readyOf(sel), 16'd0);
        for (int i = 1; i < n; i++) begin
            tick;
            checkOutput("no early done", doneOf(sel), 16'd0);
            checkOutput("hold prior digits", digitsOf(sel), prevBcd);
        end
        tick;
        checkOutput("done pulse", doneOf(sel), 16'd1);
        checkOutput("result digits", digitsOf(sel), expBcd);
        checkOutput("not ready in done", readyOf(sel), 16'd0);
        tick;
        checkOutput("done one cycle", doneOf(sel), 16'd0);
        checkOutput("ready after done", readyOf(sel), 16'd1);
        checkOutput("result held", digitsOf(sel), expBcd);
    endtask

    // Directed sequence of steps.
    initial begin
        reset = 1'b1;
        applyStimulus(8, 1'b0, 0);
        applyStimulus(13, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ready8", readyOf(8), 16'd1);
        checkOutput("reset done8", doneOf(8), 16'd0);
        checkOutput("reset digits8", digitsOf(8), 16'h0000);
        checkOutput("reset ready13", readyOf(13), 16'd1);
        checkOutput("reset digits13", digitsOf(13), 16'h0000);
        reset = 1'b0;
        tick;
        checkOutput("idle ready8", readyOf(8), 16'd1);
        checkOutput("idle done8", doneOf(8), 16'd0);

        runConversion(8, 255, 16'h0255, 16'h0000);
        runConversion(8, 0,   16'h0000, 16'h0255);
        runConversion(8, 99,  16'h0099, 16'h0000);
        runConversion(8, 100, 16'h0100, 16'h0099);

        // A start pulse during OP must be ignored and not queued.
        applyStimulus(8, 1'b1, 42);
        tick;
        applyStimulus(8, 1'b0, 0);
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (i == 2) applyStimulus(8, 1'b1, 7);
            if (i == 3) applyStimulus(8, 1'b0, 0);
            if (i < 8) begin
                checkOutput("ignored start busy", readyOf(8), 16'd0);
                checkOutput("ignored start no done", doneOf(8), 16'd0);
                checkOutput("ignored start hold", digitsOf(8), 16'h0100);
            end else begin
                checkOutput("ignored start done", doneOf(8), 16'd1);
                checkOutput("ignored start result", digitsOf(8), 16'h0042);
            end
        end
        for (int i = 1; i <= 9; i++) begin
            tick;
            checkOutput("no queued conversion", doneOf(8), 16'd0);
            checkOutput("result 42 kept", digitsOf(8), 16'h0042);
        end

        // Reset mid-conversion clears outputs without waiting for a clock edge.
        applyStimulus(8, 1'b1, 200);
        tick;
        applyStimulus(8, 1'b0, 0);
        repeat (4) begin
            tick;
            checkOutput("abort pre-reset no done", doneOf(8), 16'd0);
        end
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async clear digits", digitsOf(8), 16'h0000);
        checkOutput("async ready", readyOf(8), 16'd1);
        checkOutput("async done", doneOf(8), 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick;
            checkOutput("aborted no done", doneOf(8), 16'd0);
            checkOutput("aborted idle", readyOf(8), 16'd1);
        end
        runConversion(8, 17, 16'h0017, 16'h0000);

        // Widest legal input on the 13-bit instance.
        runConversion(13, 8191, 16'h8191, 16'h0000);

        // start held high: a new conversion every N+2 = 15 cycles.
        applyStimulus(13, 1'b1, 1234);
        tick;
        for (int j = 0; j < 3; j++) begin
            for (int i = 1; i <= 15; i++) begin
                tick;
                checkOutput("back-to-back done", doneOf(13), {15'd0, i == 13});
                if (i == 13) checkOutput("back-to-back result", digitsOf(13), 16'h1234);
                if (i == 14) checkOutput("back-to-back ready", readyOf(13), 16'd1);
            end
        end
        applyStimulus(13, 1'b0, 0);
        repeat (20) tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
